normalize_shift_ctrl: RTL and testbench

- Multi-cycle left-normalizer in the FPU add/sub datapath, directly upstream of the exponent subtract stage.
- Takes an unnormalized mantissa and its exponent, then shifts the mantissa left one bit per cycle until the hidden-bit position is 1.
- Shifting also stops when the mantissa is zero or the shift count reaches the exponent (denormal limit).
- Emits the normalized mantissa, the unchanged exponent, and shifted_amount. The subtract stage consumes the exponent and shifted_amount and computes exp − shifted_amount.

---
 rtl/fpu_norm_pkg.sv | 15 +
 rtl/normalize_shift_ctrl.sv | 85 ++++++++
 tb/tb_normalize_shift_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_norm_pkg.sv
// Shared types and widths for the FPU add/sub normalize and exponent-subtract stages.
package fpu_norm_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_t;

  typedef logic [EXP_W-1:0] shift_cnt_t;

endpackage

// File: rtl/normalize_shift_ctrl.sv
// Multi-cycle left normalizer: shifts one bit per cycle until the hidden bit is set,
// the mantissa is zero, or the shift count reaches the exponent.
module normalize_shift_ctrl #(
  parameter int MANT_W = fpu_norm_pkg::MANT_W,
  parameter int EXP_W  = fpu_norm_pkg::EXP_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [EXP_W-1:0]  out_shifted_amount,
  output logic              out_sign,
  output logic              out_zero
);
  import fpu_norm_pkg::*;

  norm_state_t       r_state;
  logic [MANT_W-1:0] r_mant;
  logic [EXP_W-1:0]  r_exp;
  logic [EXP_W-1:0]  r_count;
  logic              r_sign;
  logic              r_zero;
  logic              r_out_valid;
  logic              w_stop;

  // Zero test first, then hidden bit, then the denormal limit keeps exp - count >= 0.
  assign w_stop = (r_mant == '0) || r_mant[MANT_W-1] || (r_count == r_exp);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_mant      <= '0;
      r_exp       <= '0;
      r_count     <= '0;
      r_sign      <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mant  <= in_mant;
            r_exp   <= in_exp;
            r_sign  <= in_sign;
            r_count <= '0;
            r_zero  <= (in_mant == '0);
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_stop) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_mant  <= r_mant << 1;
            r_count <= r_count + EXP_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready           = (r_state == IDLE);
  assign out_valid          = r_out_valid;
  assign out_mant           = r_mant;
  assign out_exp            = r_exp;
  assign out_shifted_amount = r_count;
  assign out_sign           = r_sign;
  assign out_zero           = r_zero;

endmodule

// File: tb/tb_normalize_shift_ctrl.sv
// Self-checking bench for normalize_shift_ctrl: directed vectors, random operands, handshake corners.
module tb_normalize_shift_ctrl;
  localparam int MW = 27;
  localparam int EW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_mant;
  logic [EW-1:0] in_exp;
  logic          in_sign;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic [EW-1:0] out_shifted_amount;
  logic          out_sign;
  logic          out_zero;

  int errors = 0;
  int checks = 0;

  normalize_shift_ctrl #(.MANT_W(MW), .EXP_W(EW)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp),
    .out_shifted_amount(out_shifted_amount),
    .out_sign(out_sign), .out_zero(out_zero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic          sign;
    logic [MW-1:0] exp_mant;
    logic [EW-1:0] exp_shift;
    logic          exp_zero;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: shift = min(leading zeros, exponent), none for a zero mantissa.
  function automatic void ref_model(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                    output logic [MW-1:0] om, output logic [EW-1:0] sh);
    int lz;
    int s;
    lz = MW;
    for (int i = 0; i < MW; i++) if (m[i]) lz = MW - 1 - i;
    if (m == '0) s = 0;
    else s = (lz < int'(e)) ? lz : int'(e);
    om = m << s;
    sh = EW'(s);
  endfunction

  task automatic run_op(input string name, input logic [MW-1:0] m, input logic [EW-1:0] e,
                        input logic s, input logic [MW-1:0] xm, input logic [EW-1:0] xsh,
                        input logic xz);
    int cyc;
    @(negedge CLK);
    chk({name, ".in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; in_mant = m; in_exp = e; in_sign = s;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!out_valid && cyc < 60);
    chk({name, ".latency"}, cyc, int'(xsh) + 2);
    chk({name, ".mant"}, out_mant, xm);
    chk({name, ".shift"}, out_shifted_amount, xsh);
    chk({name, ".exp"}, out_exp, e);
    chk({name, ".sign"}, out_sign, s);
    chk({name, ".zero"}, out_zero, xz);
    chk({name, ".in_ready_done"}, in_ready, 0);
    chk({name, ".sub"}, EW'(out_exp - out_shifted_amount), EW'(e - xsh));
    out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
    @(negedge CLK);
    chk({name, ".valid_drop"}, out_valid, 0);
    chk({name, ".in_ready_back"}, in_ready, 1);
  endtask

  vec_t vecs[7];

  initial begin
    logic [MW-1:0] hold_mant;
    logic [EW-1:0] hold_shift;
    int cyc;
    int spurious;

    vecs[0] = '{27'h4000000, 8'd127, 1'b0, 27'h4000000, 8'd0,  1'b0};
    vecs[1] = '{27'h0800000, 8'd100, 1'b1, 27'h4000000, 8'd3,  1'b0};
    vecs[2] = '{27'h0000100, 8'd5,   1'b0, 27'h0002000, 8'd5,  1'b0};
    vecs[3] = '{27'h0000000, 8'd50,  1'b1, 27'h0000000, 8'd0,  1'b1};
    vecs[4] = '{27'h0000123, 8'd0,   1'b0, 27'h0000123, 8'd0,  1'b0};
    vecs[5] = '{27'h0000001, 8'd200, 1'b1, 27'h4000000, 8'd26, 1'b0};
    vecs[6] = '{27'h0000001, 8'd26,  1'b0, 27'h4000000, 8'd26, 1'b0};

    RST = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; in_sign = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.mant", out_mant, 0);
    chk("rst.exp", out_exp, 0);
    chk("rst.shift", out_shifted_amount, 0);
    chk("rst.sign_zero", {out_sign, out_zero}, 0);

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].mant, vecs[i].exp, vecs[i].sign,
             vecs[i].exp_mant, vecs[i].exp_shift, vecs[i].exp_zero);
    chk("vec1.sub_97", 8'd100 - vecs[1].exp_shift, 8'd97);

    for (int i = 0; i < 40; i++) begin
      logic [MW-1:0] m, xm;
      logic [EW-1:0] e, xsh;
      m = MW'($urandom) >> $urandom_range(0, MW);
      e = (i % 2 == 0) ? EW'($urandom_range(0, 30)) : EW'($urandom);
      ref_model(m, e, xm, xsh);
      run_op($sformatf("rnd%0d", i), m, e, 1'($urandom), xm, xsh, m == '0);
    end

    // Backpressure: result must hold unchanged while out_ready stays low.
    @(negedge CLK);
    in_valid = 1'b1; in_mant = 27'h0800000; in_exp = 8'd100; in_sign = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!out_valid && cyc < 60);
    chk("bp.latency", cyc, 5);
    hold_mant = out_mant;
    hold_shift = out_shifted_amount;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("bp.valid", out_valid, 1);
      chk("bp.in_ready", in_ready, 0);
      chk("bp.mant", out_mant, hold_mant);
      chk("bp.shift", out_shifted_amount, hold_shift);
    end
    chk("bp.mant_val", hold_mant, 27'h4000000);

    // New operand offered in the same cycle DONE completes: not taken until IDLE.
    out_ready = 1'b1; in_valid = 1'b1; in_mant = 27'h0000001; in_exp = 8'd100; in_sign = 1'b0;
    @(posedge CLK);
    #1 out_ready = 1'b0;
    @(negedge CLK);
    chk("same.in_ready", in_ready, 1);
    chk("same.out_valid", out_valid, 0);
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("mid.in_ready", in_ready, 0);
    chk("mid.out_valid", out_valid, 0);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid.out_valid", out_valid, 0);
    chk("rst_mid.in_ready", in_ready, 1);
    chk("rst_mid.mant", out_mant, 0);
    chk("rst_mid.shift", out_shifted_amount, 0);
    spurious = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (out_valid) spurious++;
    end
    chk("rst_mid.no_output", spurious, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
